hpdcache_mem_read_arbiter: RTL and testbench
============================================

HPDCACHE_MEM_READ_ARBITER -- requirements
Module: hpdcache_mem_read_arbiter

Interface
- REQ-001 SHALL have parameter NSRC, default 2: number of upstream read-request sources (2..8).
- REQ-002 SHALL have parameter ADDR_W, default 56: memory address width.
- REQ-003 SHALL have parameter SRC_ID_W, default 7: upstream transaction ID width.
- REQ-004 SHALL have parameter DATA_W, default 512: read-response data width.
- REQ-005 SHALL have parameter MAX_OUTST, default 8: outstanding-transaction limit per source (power of 2).
- REQ-006 SHALL derive SEL_W = max(1, $clog2(NSRC)) and MEM_ID_W = SRC_ID_W + SEL_W.
- REQ-007 SHALL have port clk_i, input, 1: single clock, rising edge.
- REQ-008 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
- REQ-009 SHALL have port src_req_valid_i, input, NSRC: per-source request valid.
- REQ-010 SHALL have port src_req_ready_o, output, NSRC: per-source request accepted.
- REQ-011 SHALL have port src_req_addr_i, input, NSRC*ADDR_W: per-source address, source s at bits [s*ADDR_W +: ADDR_W].
- REQ-012 SHALL have port src_req_id_i, input, NSRC*SRC_ID_W: per-source ID, packed the same way.
- REQ-013 SHALL have ports mem_req_valid_o output 1, mem_req_ready_i input 1, mem_req_addr_o output ADDR_W, mem_req_id_o output MEM_ID_W: the merged downstream request.
- REQ-014 SHALL have ports mem_rsp_valid_i input 1, mem_rsp_ready_o output 1, mem_rsp_id_i input MEM_ID_W, mem_rsp_data_i input DATA_W, mem_rsp_last_i input 1: the downstream response.
- REQ-015 SHALL have ports src_rsp_valid_o output NSRC, src_rsp_ready_i input NSRC, src_rsp_id_o output SRC_ID_W, src_rsp_data_o output DATA_W, src_rsp_last_o output 1: the routed response; id, data and last are shared by all sources.

Function
- REQ-016 SHALL register the downstream request in a one-entry output stage, giving 1-cycle latency from source acceptance to mem_req_valid_o.
- REQ-017 SHALL accept a source request only when the output stage is empty or is being drained in the same cycle (mem_req_ready_i=1); this gives full throughput.
- REQ-018 SHALL grant round-robin: search begins at pointer ptr; after an acceptance from source s, ptr becomes (s+1) mod NSRC; ptr stays unchanged in idle cycles.
- REQ-019 SHALL assert src_req_ready_o for at most one source per cycle, and only for the granted source.
- REQ-020 SHALL set mem_req_id_o = {granted source index (SEL_W bits), source ID}.
- REQ-021 SHALL hold mem_req_valid_o, addr and id stable until mem_req_ready_i=1.
- REQ-022 SHALL route each response beat to source s = mem_rsp_id_i[MEM_ID_W-1 -: SEL_W], with src_rsp_id_o = mem_rsp_id_i[SRC_ID_W-1:0].
- REQ-023 SHALL drive mem_rsp_ready_o combinationally as src_rsp_ready_i[s]; response data is not buffered.
- REQ-024 SHALL, for a response whose index s is >= NSRC, assert mem_rsp_ready_o, drop the beat and set sticky flag err_q; err_q is internal and visible to assertions only.

Reset
- REQ-025 SHALL, while rst_ni=0, drive mem_req_valid_o=0, src_req_ready_o=0 and src_rsp_valid_o=0, set ptr=0, clear all outstanding counters and clear err_q.
- REQ-026 SHALL, on reset assertion mid-transfer, discard the output-stage contents with no replay.
- REQ-027 SHALL resume arbitration on the first clock edge after rst_ni deasserts.

Configuration
- REQ-028 SHALL, with HPDCACHE_RDARB_OUTST_LIMIT_EN defined, keep a $clog2(MAX_OUTST)+1-bit counter per source.
  - Increment on request acceptance from that source.
  - Decrement on a response handshake with mem_rsp_last_i=1 routed to that source.
  - Simultaneous increment and decrement leave the counter unchanged.
  - A source whose counter equals MAX_OUTST is excluded from arbitration; other sources are still granted.
- REQ-029 SHALL, without HPDCACHE_RDARB_OUTST_LIMIT_EN, have no counters and no source exclusion.

Verification
- REQ-030 SHALL cover: NSRC=2, both sources continuously valid, mem_req_ready_i=1 -> grants alternate 0,1,0,1; one request per cycle; mem_req_id_o MSB alternates.
- REQ-031 SHALL cover: source 1 sends id=0x15, addr=0x1000, while mem_req_ready_i is held 0 for 3 cycles -> mem_req_valid_o=1 with id=0x95 and addr stable for 4 cycles; no further source accepted.
- REQ-032 SHALL cover: a 2-beat response with id=0x83, src_rsp_ready_i[1]=0 for 2 cycles -> mem_rsp_ready_o=0 for those cycles; then beats delivered to source 1 with id 0x03, last on beat 2.
- REQ-033 SHALL cover: with the macro defined and MAX_OUTST=8, source 0 issues 8 requests and receives no responses -> 9th request stalled while source 1 is still granted; one last-beat response to source 0 -> the 9th request is accepted next cycle.
- REQ-034 SHALL cover: rst_ni pulled low while mem_req_valid_o=1 -> mem_req_valid_o=0 immediately (asynchronous); after release, the first grant goes to source 0.
- REQ-035 SHALL cover: NSRC=3 with a response id index of 3 -> beat consumed, no src_rsp_valid_o asserted, err_q=1.

Source files
------------

// File: rtl/hpdcache_mem_read_arbiter.sv
// Round-robin merge of NSRC read-request streams into one registered memory request port,
// with ID-based routing of read responses back to the originating source.
// Optional per-source outstanding limit: define HPDCACHE_RDARB_OUTST_LIMIT_EN.
//
// Handshake: a transfer occurs on a rising clk_i edge where valid and ready are both 1.
// Valid never waits on ready; the payload stays stable while valid=1 and ready=0.
module hpdcache_mem_read_arbiter #(
  parameter int unsigned NSRC      = 2,
  parameter int unsigned ADDR_W    = 56,
  parameter int unsigned SRC_ID_W  = 7,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned MAX_OUTST = 8,
  localparam int unsigned SEL_W    = (NSRC > 1) ? $clog2(NSRC) : 1,
  localparam int unsigned MEM_ID_W = SRC_ID_W + SEL_W
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NSRC-1:0]            src_req_valid_i,
  output logic [NSRC-1:0]            src_req_ready_o,
  input  logic [NSRC*ADDR_W-1:0]     src_req_addr_i,
  input  logic [NSRC*SRC_ID_W-1:0]   src_req_id_i,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic [ADDR_W-1:0]          mem_req_addr_o,
  output logic [MEM_ID_W-1:0]        mem_req_id_o,
  input  logic                       mem_rsp_valid_i,
  output logic                       mem_rsp_ready_o,
  input  logic [MEM_ID_W-1:0]        mem_rsp_id_i,
  input  logic [DATA_W-1:0]          mem_rsp_data_i,
  input  logic                       mem_rsp_last_i,
  output logic [NSRC-1:0]            src_rsp_valid_o,
  input  logic [NSRC-1:0]            src_rsp_ready_i,
  output logic [SRC_ID_W-1:0]        src_rsp_id_o,
  output logic [DATA_W-1:0]          src_rsp_data_o,
  output logic                       src_rsp_last_o
);

  logic                r_valid;
  logic [ADDR_W-1:0]   r_addr;
  logic [MEM_ID_W-1:0] r_id;
  logic [SEL_W-1:0]    r_ptr;
  logic                err_q;

  logic [NSRC-1:0]     w_limit;
  logic [NSRC-1:0]     w_eligible;
  logic                w_stage_free;
  logic                w_grant_vld;
  logic [SEL_W-1:0]    w_grant_idx;
  logic                w_accept;
  logic [SEL_W-1:0]    w_rsp_sel;
  logic                w_rsp_in_range;
  logic                w_rsp_hs;

  assign w_eligible   = src_req_valid_i & ~w_limit;
  assign w_stage_free = !r_valid || mem_req_ready_i;
  assign w_accept     = w_grant_vld && w_stage_free;

  // Scan from the highest offset down so the first eligible source at or after r_ptr wins.
  always_comb begin
    int idx;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    idx         = 0;
    for (int k = int'(NSRC) - 1; k >= 0; k--) begin
      idx = (int'(r_ptr) + k) % int'(NSRC);
      if (w_eligible[idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    src_req_ready_o = '0;
    if (rst_ni && w_accept) src_req_ready_o[w_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_addr  <= src_req_addr_i[int'(w_grant_idx)*ADDR_W +: ADDR_W];
      r_id    <= {w_grant_idx, src_req_id_i[int'(w_grant_idx)*SRC_ID_W +: SRC_ID_W]};
      r_ptr   <= SEL_W'((int'(w_grant_idx) + 1) % int'(NSRC));
    end else if (mem_req_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign mem_req_valid_o = r_valid;
  assign mem_req_addr_o  = r_addr;
  assign mem_req_id_o    = r_id;

  // Responses are not buffered: the selected source's ready is passed straight back.
  assign w_rsp_sel      = mem_rsp_id_i[MEM_ID_W-1 -: SEL_W];
  assign w_rsp_in_range = int'(w_rsp_sel) < int'(NSRC);
  assign mem_rsp_ready_o = w_rsp_in_range ? src_rsp_ready_i[w_rsp_sel] : 1'b1;
  assign w_rsp_hs       = mem_rsp_valid_i && mem_rsp_ready_o;
  assign src_rsp_id_o   = mem_rsp_id_i[SRC_ID_W-1:0];
  assign src_rsp_data_o = mem_rsp_data_i;
  assign src_rsp_last_o = mem_rsp_last_i;

  always_comb begin
    src_rsp_valid_o = '0;
    if (rst_ni && mem_rsp_valid_i && w_rsp_in_range) src_rsp_valid_o[w_rsp_sel] = 1'b1;
  end

  // Out-of-range response indices are consumed and leave a sticky error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                  err_q <= 1'b0;
    else if (mem_rsp_valid_i && !w_rsp_in_range)  err_q <= 1'b1;
  end

`ifdef HPDCACHE_RDARB_OUTST_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;

  logic [CNT_W-1:0] r_outst [NSRC];

  for (genvar gs = 0; gs < int'(NSRC); gs++) begin : g_outst
    logic w_inc;
    logic w_dec;
    assign w_inc       = src_req_ready_o[gs];
    assign w_dec       = w_rsp_hs && mem_rsp_last_i && w_rsp_in_range &&
                         (w_rsp_sel == SEL_W'(gs));
    assign w_limit[gs] = (r_outst[gs] == CNT_W'(MAX_OUTST));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)             r_outst[gs] <= '0;
      else if (w_inc && !w_dec) r_outst[gs] <= r_outst[gs] + 1'b1;
      else if (w_dec && !w_inc) r_outst[gs] <= r_outst[gs] - 1'b1;
    end
  end
`else
  assign w_limit = '0;
`endif

endmodule

// File: tb/tb_hpdcache_mem_read_arbiter.sv
// Directed self-checking bench for hpdcache_mem_read_arbiter: a 2-source instance
// for arbitration/routing/reset and a 3-source instance for the out-of-range response path.
module tb_hpdcache_mem_read_arbiter;

  logic clk;
  logic rst_n;

  // 2-source instance (defaults: ADDR_W=56, SRC_ID_W=7, DATA_W=512 -> MEM_ID_W=8)
  logic [1:0]     src_req_valid;
  logic [1:0]     src_req_ready;
  logic [111:0]   src_req_addr;
  logic [13:0]    src_req_id;
  logic           mem_req_valid;
  logic           mem_req_ready;
  logic [55:0]    mem_req_addr;
  logic [7:0]     mem_req_id;
  logic           mem_rsp_valid;
  logic           mem_rsp_ready;
  logic [7:0]     mem_rsp_id;
  logic [511:0]   mem_rsp_data;
  logic           mem_rsp_last;
  logic [1:0]     src_rsp_valid;
  logic [1:0]     src_rsp_ready;
  logic [6:0]     src_rsp_id;
  logic [511:0]   src_rsp_data;
  logic           src_rsp_last;

  // 3-source instance (MEM_ID_W=9)
  logic [2:0]     t3_req_valid;
  logic [2:0]     t3_req_ready;
  logic [167:0]   t3_req_addr;
  logic [20:0]    t3_req_id;
  logic           t3_mem_req_valid;
  logic           t3_mem_req_ready;
  logic [55:0]    t3_mem_req_addr;
  logic [8:0]     t3_mem_req_id;
  logic           t3_rsp_valid;
  logic           t3_rsp_ready;
  logic [8:0]     t3_rsp_id;
  logic [511:0]   t3_rsp_data;
  logic           t3_rsp_last;
  logic [2:0]     t3_src_rsp_valid;
  logic [2:0]     t3_src_rsp_ready;
  logic [6:0]     t3_src_rsp_id;
  logic [511:0]   t3_src_rsp_data;
  logic           t3_src_rsp_last;

  int n_checks;
  int n_fail;

  hpdcache_mem_read_arbiter u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .src_req_valid_i(src_req_valid), .src_req_ready_o(src_req_ready),
    .src_req_addr_i(src_req_addr), .src_req_id_i(src_req_id),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_req_addr_o(mem_req_addr), .mem_req_id_o(mem_req_id),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_ready_o(mem_rsp_ready),
    .mem_rsp_id_i(mem_rsp_id), .mem_rsp_data_i(mem_rsp_data), .mem_rsp_last_i(mem_rsp_last),
    .src_rsp_valid_o(src_rsp_valid), .src_rsp_ready_i(src_rsp_ready),
    .src_rsp_id_o(src_rsp_id), .src_rsp_data_o(src_rsp_data), .src_rsp_last_o(src_rsp_last)
  );

  hpdcache_mem_read_arbiter #(.NSRC(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .src_req_valid_i(t3_req_valid), .src_req_ready_o(t3_req_ready),
    .src_req_addr_i(t3_req_addr), .src_req_id_i(t3_req_id),
    .mem_req_valid_o(t3_mem_req_valid), .mem_req_ready_i(t3_mem_req_ready),
    .mem_req_addr_o(t3_mem_req_addr), .mem_req_id_o(t3_mem_req_id),
    .mem_rsp_valid_i(t3_rsp_valid), .mem_rsp_ready_o(t3_rsp_ready),
    .mem_rsp_id_i(t3_rsp_id), .mem_rsp_data_i(t3_rsp_data), .mem_rsp_last_i(t3_rsp_last),
    .src_rsp_valid_o(t3_src_rsp_valid), .src_rsp_ready_i(t3_src_rsp_ready),
    .src_rsp_id_o(t3_src_rsp_id), .src_rsp_data_o(t3_src_rsp_data), .src_rsp_last_o(t3_src_rsp_last)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic idle_inputs;
    src_req_valid = '0; src_req_addr = '0; src_req_id = '0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_id = '0; mem_rsp_data = '0; mem_rsp_last = 1'b0;
    src_rsp_ready = '0;
    t3_req_valid = '0; t3_req_addr = '0; t3_req_id = '0; t3_mem_req_ready = 1'b0;
    t3_rsp_valid = 1'b0; t3_rsp_id = '0; t3_rsp_data = '0; t3_rsp_last = 1'b0;
    t3_src_rsp_ready = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    src_req_valid = 2'b11;
    mem_rsp_valid = 1'b1;
    mem_rsp_id    = 8'h81;
    #3;
    n_checks++;
    if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid: got %b expected 0", mem_req_valid); end
    n_checks++;
    if (src_req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", src_req_ready); end
    n_checks++;
    if (src_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 00", src_rsp_valid); end
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_round_robin;
    logic [7:0] exp_id;
    src_req_addr  = {56'hB0, 56'hA0};
    src_req_id    = {7'h02, 7'h01};
    src_req_valid = 2'b11;
    mem_req_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (src_req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b", k, src_req_ready);
      end
      tick();
      exp_id = (k % 2 == 0) ? 8'h01 : 8'h82;
      n_checks++;
      if (mem_req_valid !== 1'b1 || mem_req_id !== exp_id) begin
        n_fail++; $display("FAIL rr_mem_req[%0d]: got valid=%b id=%h expected valid=1 id=%h", k, mem_req_valid, mem_req_id, exp_id);
      end
      n_checks++;
      if (mem_req_addr !== ((k % 2 == 0) ? 56'hA0 : 56'hB0)) begin
        n_fail++; $display("FAIL rr_addr[%0d]: got %h", k, mem_req_addr);
      end
    end
    src_req_valid = 2'b00;
    tick();
    n_checks++;
    if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %b expected 0", mem_req_valid); end
  endtask

  task automatic test_backpressure;
    src_req_addr  = {56'h1000, 56'h2222};
    src_req_id    = {7'h15, 7'h44};
    src_req_valid = 2'b10;
    mem_req_ready = 1'b0;
    #1;
    n_checks++;
    if (src_req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_grant: got %b expected 10", src_req_ready); end
    tick();
    src_req_valid = 2'b01;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (mem_req_valid !== 1'b1 || mem_req_id !== 8'h95 || mem_req_addr !== 56'h1000) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b id=%h addr=%h expected 1/95/1000", i, mem_req_valid, mem_req_id, mem_req_addr);
      end
      n_checks++;
      if (src_req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_no_accept[%0d]: got %b expected 00", i, src_req_ready); end
      tick();
    end
    src_req_valid = 2'b00;
    mem_req_ready = 1'b1;
    #1;
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_id !== 8'h95 || mem_req_addr !== 56'h1000) begin
      n_fail++; $display("FAIL bp_hold_last: got valid=%b id=%h addr=%h", mem_req_valid, mem_req_id, mem_req_addr);
    end
    tick();
    n_checks++;
    if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", mem_req_valid); end
    mem_req_ready = 1'b0;
  endtask

  task automatic test_rsp_route;
    mem_rsp_valid = 1'b1;
    mem_rsp_id    = 8'h83;
    mem_rsp_data  = 512'hD1;
    mem_rsp_last  = 1'b0;
    src_rsp_ready = 2'b00;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (mem_rsp_ready !== 1'b0 || src_rsp_valid !== 2'b10) begin
        n_fail++; $display("FAIL rsp_stall[%0d]: got ready=%b valid=%b expected 0/10", i, mem_rsp_ready, src_rsp_valid);
      end
      tick();
    end
    src_rsp_ready = 2'b10;
    #1;
    n_checks++;
    if (mem_rsp_ready !== 1'b1 || src_rsp_id !== 7'h03 || src_rsp_data !== 512'hD1 || src_rsp_last !== 1'b0) begin
      n_fail++; $display("FAIL rsp_beat1: got ready=%b id=%h data=%h last=%b", mem_rsp_ready, src_rsp_id, src_rsp_data[31:0], src_rsp_last);
    end
    tick();
    mem_rsp_data = 512'hD2;
    mem_rsp_last = 1'b1;
    #1;
    n_checks++;
    if (mem_rsp_ready !== 1'b1 || src_rsp_valid !== 2'b10 || src_rsp_data !== 512'hD2 || src_rsp_last !== 1'b1) begin
      n_fail++; $display("FAIL rsp_beat2: got ready=%b valid=%b data=%h last=%b", mem_rsp_ready, src_rsp_valid, src_rsp_data[31:0], src_rsp_last);
    end
    tick();
    mem_rsp_id    = 8'h05;
    src_rsp_ready = 2'b01;
    #1;
    n_checks++;
    if (src_rsp_valid !== 2'b01 || src_rsp_id !== 7'h05 || mem_rsp_ready !== 1'b1) begin
      n_fail++; $display("FAIL rsp_src0: got valid=%b id=%h ready=%b expected 01/05/1", src_rsp_valid, src_rsp_id, mem_rsp_ready);
    end
    tick();
    mem_rsp_valid = 1'b0;
    src_rsp_ready = 2'b00;
    #1;
    n_checks++;
    if (src_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rsp_idle: got %b expected 00", src_rsp_valid); end
  endtask

  task automatic test_reset_mid;
    src_req_addr  = {56'h77, 56'h66};
    src_req_id    = {7'h22, 7'h33};
    src_req_valid = 2'b01;
    mem_req_ready = 1'b0;
    tick();
    src_req_valid = 2'b00;
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_id !== 8'h33) begin
      n_fail++; $display("FAIL rm_pre: got valid=%b id=%h expected 1/33", mem_req_valid, mem_req_id);
    end
    #2;
    rst_n = 1'b0;
    src_req_valid = 2'b11;
    #1;
    n_checks++;
    if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rm_async_clear: got %b expected 0", mem_req_valid); end
    n_checks++;
    if (src_req_ready !== 2'b00) begin n_fail++; $display("FAIL rm_ready_low: got %b expected 00", src_req_ready); end
    tick();
    rst_n = 1'b1;
    mem_req_ready = 1'b1;
    #1;
    n_checks++;
    if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_replay: got %b expected 0", mem_req_valid); end
    n_checks++;
    if (src_req_ready !== 2'b01) begin n_fail++; $display("FAIL rm_first_grant: got %b expected 01", src_req_ready); end
    tick();
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_id !== 8'h33) begin
      n_fail++; $display("FAIL rm_resume: got valid=%b id=%h expected 1/33", mem_req_valid, mem_req_id);
    end
    src_req_valid = 2'b00;
    tick();
  endtask

`ifdef HPDCACHE_RDARB_OUTST_LIMIT_EN
  task automatic test_outst_limit;
    idle_inputs();
    apply_reset();
    src_req_id    = {7'h02, 7'h01};
    src_req_valid = 2'b01;
    mem_req_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (src_req_ready !== 2'b01) begin n_fail++; $display("FAIL ol_accept[%0d]: got %b expected 01", i, src_req_ready); end
      tick();
    end
    n_checks++;
    if (src_req_ready !== 2'b00) begin n_fail++; $display("FAIL ol_stall: got %b expected 00", src_req_ready); end
    src_req_valid = 2'b11;
    #1;
    n_checks++;
    if (src_req_ready !== 2'b10) begin n_fail++; $display("FAIL ol_other_src: got %b expected 10", src_req_ready); end
    tick();
    src_req_valid = 2'b01;
    mem_rsp_valid = 1'b1;
    mem_rsp_id    = 8'h01;
    mem_rsp_last  = 1'b1;
    src_rsp_ready = 2'b01;
    #1;
    n_checks++;
    if (src_req_ready !== 2'b00 || mem_rsp_ready !== 1'b1) begin
      n_fail++; $display("FAIL ol_rsp_cycle: got req_ready=%b rsp_ready=%b expected 00/1", src_req_ready, mem_rsp_ready);
    end
    tick();
    mem_rsp_valid = 1'b0;
    src_rsp_ready = 2'b00;
    #1;
    n_checks++;
    if (src_req_ready !== 2'b01) begin n_fail++; $display("FAIL ol_release: got %b expected 01", src_req_ready); end
    tick();
    idle_inputs();
  endtask
`endif

  task automatic test_nsrc3;
    logic [2:0] exp_rdy;
    logic [8:0] exp_id;
    idle_inputs();
    apply_reset();
    t3_req_id        = {7'h0A, 7'h0A, 7'h0A};
    t3_req_valid     = 3'b111;
    t3_mem_req_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_rdy = (k % 3 == 0) ? 3'b001 : ((k % 3 == 1) ? 3'b010 : 3'b100);
      exp_id  = (k % 3 == 0) ? 9'h00A : ((k % 3 == 1) ? 9'h08A : 9'h10A);
      n_checks++;
      if (t3_req_ready !== exp_rdy) begin n_fail++; $display("FAIL n3_grant[%0d]: got %b expected %b", k, t3_req_ready, exp_rdy); end
      tick();
      n_checks++;
      if (t3_mem_req_id !== exp_id) begin n_fail++; $display("FAIL n3_id[%0d]: got %h expected %h", k, t3_mem_req_id, exp_id); end
    end
    t3_req_valid     = 3'b000;
    t3_rsp_valid     = 1'b1;
    t3_rsp_id        = 9'h111;
    t3_src_rsp_ready = 3'b000;
    #1;
    n_checks++;
    if (t3_src_rsp_valid !== 3'b100 || t3_src_rsp_id !== 7'h11 || t3_rsp_ready !== 1'b0) begin
      n_fail++; $display("FAIL n3_route2: got valid=%b id=%h ready=%b expected 100/11/0", t3_src_rsp_valid, t3_src_rsp_id, t3_rsp_ready);
    end
    t3_rsp_id = 9'h185;
    #1;
    n_checks++;
    if (t3_rsp_ready !== 1'b1 || t3_src_rsp_valid !== 3'b000) begin
      n_fail++; $display("FAIL n3_bad_consume: got ready=%b valid=%b expected 1/000", t3_rsp_ready, t3_src_rsp_valid);
    end
    n_checks++;
    if (u_dut3.err_q !== 1'b0) begin n_fail++; $display("FAIL n3_err_pre: got %b expected 0", u_dut3.err_q); end
    tick();
    t3_rsp_valid = 1'b0;
    n_checks++;
    if (u_dut3.err_q !== 1'b1) begin n_fail++; $display("FAIL n3_err_set: got %b expected 1", u_dut3.err_q); end
    tick();
    n_checks++;
    if (u_dut3.err_q !== 1'b1) begin n_fail++; $display("FAIL n3_err_sticky: got %b expected 1", u_dut3.err_q); end
    n_checks++;
    if (u_dut.err_q !== 1'b0) begin n_fail++; $display("FAIL n2_err_clear: got %b expected 0", u_dut.err_q); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_rsp_route();
    test_reset_mid();
`ifdef HPDCACHE_RDARB_OUTST_LIMIT_EN
    test_outst_limit();
`endif
    test_nsrc3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
